// File: rtl/hx711_pkg.sv
// Shared types and constants for the HX711 weight filter: state encoding,
// data widths, saturation limits and the 16-bit saturating helper.
package hx711_pkg;

  typedef enum logic [1:0] {
    ST_FILL,
    ST_TARE,
    ST_RUN
  } state_t;

  localparam int RAW_W    = 24;
  localparam int WEIGHT_W = 16;
  localparam int DIFF_W   = RAW_W + 1;
  localparam int PROD_W   = DIFF_W + 18;

  localparam logic signed [WEIGHT_W-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [WEIGHT_W-1:0] SAT_MIN = 16'sh8000;

  function automatic logic signed [WEIGHT_W-1:0] saturate(input logic signed [PROD_W-1:0] v);
    if (v > PROD_W'(SAT_MAX)) begin
      return SAT_MAX;
    end else if (v < PROD_W'(SAT_MIN)) begin
      return SAT_MIN;
    end else begin
      return v[WEIGHT_W-1:0];
    end
  endfunction

endpackage

// File: rtl/hx711_weight_filter_if.sv
// Sample-in / weight-out bus between the HX711 driver, the filter and the
// display/control logic.
interface hx711_weight_filter_if;
  import hx711_pkg::*;

  logic        [RAW_W-1:0]    sample_in;
  logic                       sample_valid;
  logic                       tare_req;
  logic signed [WEIGHT_W-1:0] weight_out;
  logic                       weight_valid;
  logic                       tare_busy;
  logic                       stable;

  modport master (
    output sample_in, sample_valid, tare_req,
    input  weight_out, weight_valid, tare_busy, stable
  );

  modport slave (
    input  sample_in, sample_valid, tare_req,
    output weight_out, weight_valid, tare_busy, stable
  );

endinterface

// File: rtl/hx711_ring_avg.sv
// Sliding window over the last 2^AVG_LOG2 raw samples with a running sum;
// sum_next exposes the post-update sum so the tare can capture it on the same edge.
module hx711_ring_avg
  import hx711_pkg::*;
#(
  parameter int AVG_LOG2 = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  input  logic        [RAW_W-1:0]          in_data,
  output logic signed [RAW_W+AVG_LOG2-1:0] sum,
  output logic signed [RAW_W+AVG_LOG2-1:0] sum_next,
  output logic                             sum_valid
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SUM_W = RAW_W + AVG_LOG2;

  logic        [RAW_W-1:0]    ring_q [DEPTH];
  logic        [AVG_LOG2-1:0] wr_ptr_q;
  logic signed [SUM_W-1:0]    new_ext;
  logic signed [SUM_W-1:0]    old_ext;

  // The slot about to be overwritten always holds the oldest sample.
  assign new_ext  = {{AVG_LOG2{in_data[RAW_W-1]}}, in_data};
  assign old_ext  = {{AVG_LOG2{ring_q[wr_ptr_q][RAW_W-1]}}, ring_q[wr_ptr_q]};
  assign sum_next = sum + new_ext - old_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ring_q[i] <= '0;
      end
      wr_ptr_q  <= '0;
      sum       <= '0;
      sum_valid <= 1'b0;
    end else begin
      sum_valid <= in_valid;
      if (in_valid) begin
        ring_q[wr_ptr_q] <= in_data;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
        sum              <= sum_next;
      end
    end
  end

endmodule

// File: rtl/hx711_weight_filter.sv
// HX711 raw-count to grams: moving average, tare, scaling and saturation.
// Optional settle detector enabled by defining HX711_STABILITY_DETECT_EN.
module hx711_weight_filter
  import hx711_pkg::*;
#(
  parameter int          AVG_LOG2      = 3,
  parameter logic [17:0] SCALE_MUL     = 18'd1000,
  parameter int          SCALE_SHIFT   = 16,
  parameter bit          TARE_ON_RESET = 1'b1,
  parameter int          STABLE_TOL    = 2,
  parameter int          STABLE_CNT    = 8
) (
  input logic                  clk,
  input logic                  rst,
  hx711_weight_filter_if.slave bus
);

  localparam int                       SUM_W    = RAW_W + AVG_LOG2;
  localparam logic [5:0]               LAST_CNT = 6'((1 << AVG_LOG2) - 1);
  localparam logic signed [PROD_W-1:0] MUL_EXT  = PROD_W'(SCALE_MUL);

  logic signed [SUM_W-1:0]    sum_q;
  logic signed [SUM_W-1:0]    sum_next;
  logic                       sum_valid;
  state_t                     state_q;
  logic        [5:0]          cnt_q;
  logic signed [RAW_W-1:0]    offset_q;
  logic                       emit_q;
  logic                       busy_q;
  logic                       tare_enter;
  logic signed [DIFF_W-1:0]   diff_q;
  logic signed [PROD_W-1:0]   prod_q;
  logic                       v1_q;
  logic                       v2_q;
  logic                       wvalid_q;
  logic signed [WEIGHT_W-1:0] weight_q;

  hx711_ring_avg #(
    .AVG_LOG2 (AVG_LOG2)
  ) u_ring (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (bus.sample_valid),
    .in_data   (bus.sample_in),
    .sum       (sum_q),
    .sum_next  (sum_next),
    .sum_valid (sum_valid)
  );

  assign tare_enter = bus.tare_req && (state_q != ST_TARE);

  // emit_q marks whether the sample accepted on this edge should reach the output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= TARE_ON_RESET ? ST_TARE : ST_FILL;
      busy_q   <= TARE_ON_RESET;
      cnt_q    <= '0;
      offset_q <= '0;
      emit_q   <= 1'b0;
    end else begin
      emit_q <= 1'b0;
      if (tare_enter) begin
        state_q <= ST_TARE;
        busy_q  <= 1'b1;
        cnt_q   <= bus.sample_valid ? 6'd1 : 6'd0;
      end else if (bus.sample_valid) begin
        case (state_q)
          ST_FILL: begin
            if (cnt_q == LAST_CNT) begin
              state_q <= ST_RUN;
              cnt_q   <= '0;
              emit_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 6'd1;
            end
          end
          ST_TARE: begin
            if (cnt_q == LAST_CNT) begin
              offset_q <= RAW_W'(sum_next >>> AVG_LOG2);
              state_q  <= ST_RUN;
              busy_q   <= 1'b0;
              cnt_q    <= '0;
            end else begin
              cnt_q <= cnt_q + 6'd1;
            end
          end
          ST_RUN:  emit_q <= 1'b1;
          default: state_q <= ST_FILL;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      wvalid_q <= 1'b0;
      diff_q   <= '0;
      prod_q   <= '0;
      weight_q <= '0;
    end else begin
      v1_q     <= sum_valid && emit_q;
      diff_q   <= DIFF_W'(sum_q >>> AVG_LOG2) - DIFF_W'(offset_q);
      v2_q     <= v1_q;
      prod_q   <= PROD_W'(diff_q) * MUL_EXT;
      wvalid_q <= v2_q;
      if (v2_q) begin
        weight_q <= saturate(prod_q >>> SCALE_SHIFT);
      end
    end
  end

  assign bus.weight_out   = weight_q;
  assign bus.weight_valid = wvalid_q;
  assign bus.tare_busy    = busy_q;

`ifdef HX711_STABILITY_DETECT_EN
  localparam int                   SCW = $clog2(STABLE_CNT + 1);
  localparam int                   DW  = WEIGHT_W + 1;
  localparam logic signed [DW-1:0] TOL = DW'(STABLE_TOL);

  logic signed [DW-1:0]       delta;
  logic                       in_tol;
  logic        [SCW-1:0]      scnt_q;
  logic        [SCW-1:0]      scnt_next;
  logic signed [WEIGHT_W-1:0] prev_q;
  logic                       stable_q;

  always_comb begin
    delta     = DW'(weight_q) - DW'(prev_q);
    in_tol    = (delta <= TOL) && (delta >= -TOL);
    scnt_next = '0;
    if (in_tol) begin
      scnt_next = (scnt_q == SCW'(STABLE_CNT)) ? scnt_q : scnt_q + 1'b1;
    end
  end

  // Each new output is judged against the one before it; a tare restarts settling.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q   <= '0;
      scnt_q   <= '0;
      stable_q <= 1'b0;
    end else begin
      if (wvalid_q) begin
        prev_q <= weight_q;
      end
      if (tare_enter) begin
        scnt_q   <= '0;
        stable_q <= 1'b0;
      end else if (wvalid_q) begin
        scnt_q   <= scnt_next;
        stable_q <= (scnt_next >= SCW'(STABLE_CNT));
      end
    end
  end

  assign bus.stable = stable_q;
`else
  assign bus.stable = (STABLE_TOL < 0) && (STABLE_CNT < 0);
`endif

endmodule
